pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the Balotelli 5-stage core. Sits beside Ex and drives the PC/IF/ID/Ex boundaries.
//  Resolves jump redirects from Ex, load-use holds from Id, memory-busy holds and Ebreak halt.
//  Each cycle it produces one stall/flush/redirect decision.
//  An FSM with counters sequences post-reset hold and multi-cycle flush bubbles.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles FlushIdExOut stays high after a taken jump (incl. the jump cycle); legal 1..7
//  RESET_CYCLES  2   cycles all stalls stay high after reset release; legal 1..15
//  PC_RESET      64'h8000_0000  redirect address issued on RESET->RUN
// PORTS
//  Clk               in   1   core clock, rising edge
//  Rst               in   1   asynchronous, active-low reset
//  JumpFlagFromEx    in   1   Ex resolved a taken jump this cycle
//  JumpAddrFromEx    in   64  jump target (`AddrBus), valid with JumpFlagFromEx
//  EbreakFromEx      in   1   Ex holds an EBREAK (OpCode 7'b1110011, imm 12'h001)
//  HoldReqFromId     in   1   load-use hazard: hold PC/IF-ID, bubble into Ex
//  HoldReqFromMem    in   1   memory stage busy: freeze the whole front end
//  JumpFlagToPc      out  1   PC loads JumpAddrToPc next edge
//  JumpAddrToPc      out  64  redirect target
//  StallPcOut        out  1   PC register holds
//  StallIfIdOut      out  1   IF/ID register holds
//  StallIdExOut      out  1   ID/EX register holds
//  FlushIfIdOut      out  1   IF/ID loads a NOP
//  FlushIdExOut      out  1   ID/EX loads a NOP
//  HaltedOut         out  1   core halted by EBREAK
// BEHAVIOUR
//  States: RESET, RUN, FLUSH, HALT (2-bit). Rst low -> RESET, counter=RESET_CYCLES-1.
//  During reset: all outputs 0, except StallPc/StallIfId/StallIdEx=1.
//  RESET: all stalls=1, counter decrements each cycle. At 0: RUN; that same cycle JumpFlagToPc=1, JumpAddrToPc=PC_RESET.
//  Outputs are combinational from state+inputs; counters/state are registered.
//  RUN priority (highest first):
//   1 HoldReqFromMem: StallPc=StallIfId=StallIdEx=1, no flush, jump/ebreak ignored this cycle (Ex re-presents), stay RUN
//   2 EbreakFromEx: all stalls=1, FlushIdEx=1, next HALT
//   3 JumpFlagFromEx: JumpFlagToPc=1, JumpAddrToPc=JumpAddrFromEx, FlushIfId=FlushIdEx=1.
//     Next FLUSH if FLUSH_CYCLES>1 (counter=FLUSH_CYCLES-2), else stay RUN
//   4 HoldReqFromId: StallPc=StallIfId=1, FlushIdEx=1 (bubble), stay RUN
//   5 none: all 0
//  FLUSH: FlushIdEx=1. JumpFlag/Ebreak/HoldReqFromId ignored (Ex holds a bubble).
//   HoldReqFromMem freezes the counter and asserts all stalls.
//   Counter at 0 -> RUN.
//  HALT: all stalls=1, HaltedOut=1, flushes 0, inputs ignored; exits only via Rst.
//  JumpAddrToPc = 0 whenever JumpFlagToPc=0.
//  Rst assert mid-FLUSH/HALT: immediate return to RESET, counters reloaded.
//  A JumpFlagFromEx during FLUSH is a protocol error: the sim assertion fires and the RTL ignores it.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined: adds PerfStallCntOut, PerfFlushCntOut and PerfHaltCntOut.
//   Each is a 64-bit output, reset 0, free-running.
//   Stall counts RUN cycles with any stall; Flush counts taken jumps; Halt counts HALT cycles.
//   Counters wrap at 2^64.
//  Not defined: ports and counters are absent; no other behaviour change.
// STRUCTURE
//  defines.v: `AddrBus, state encodings `PCTRL_RESET/RUN/FLUSH/HALT, `INST_NOP.
//  Output decode from state uses MuxKeyWithDefault.
//  Sub-module pipe_ctrl_perf (counters) is instantiated only under PIPE_CTRL_PERF_EN.
// TESTING
//  1 Rst low 3 cycles then high, RESET_CYCLES=2: stalls=1 for 2 cycles.
//    Then one cycle JumpFlagToPc=1, Addr=64'h8000_0000, then RUN, all 0.
//  2 RUN, JumpFlag=1, Addr=64'h8000_0040: same cycle redirect + FlushIfId=FlushIdEx=1.
//    Next cycle FlushIdEx=1 only, then RUN.
//  3 RUN, HoldReqFromId=1 and HoldReqFromMem=1 same cycle: all three stalls=1, no flush.
//    Drop Mem: StallPc=StallIfId=1, FlushIdEx=1.
//  4 RUN, EbreakFromEx=1 with JumpFlag=1: no redirect. Next cycle HaltedOut=1, stays HALT 10 cycles despite jumps; Rst clears.
//  5 FLUSH + HoldReqFromMem 3 cycles: flush extends by 3, counter frozen. Rst mid-FLUSH -> RESET outputs immediately.
//  6 PIPE_CTRL_PERF_EN: 5 jumps + 4 stall cycles -> PerfFlushCnt=5, PerfStallCnt=4.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipe_ctrl pipeline sequencer: sequencer states, the
// per-cycle control bundle and the address type.
package pipe_ctrl_pkg;

    localparam int ADDR_W = 64;
    localparam int CNT_W  = 4;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic jump;
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic flush_if_id;
        logic flush_id_ex;
        logic halted;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{default: 1'b0};

    // Freeze every front-end boundary.
    localparam ctrl_t CTRL_HOLD_ALL = '{
        jump: 1'b0, stall_pc: 1'b1, stall_if_id: 1'b1, stall_id_ex: 1'b1,
        flush_if_id: 1'b0, flush_id_ex: 1'b0, halted: 1'b0
    };

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the Ex-side hazard sources and the pipeline sequencer.
// The performance counter outputs exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic  JumpFlagFromEx;
    addr_t JumpAddrFromEx;
    logic  EbreakFromEx;
    logic  HoldReqFromId;
    logic  HoldReqFromMem;

    logic  JumpFlagToPc;
    addr_t JumpAddrToPc;
    logic  StallPcOut;
    logic  StallIfIdOut;
    logic  StallIdExOut;
    logic  FlushIfIdOut;
    logic  FlushIdExOut;
    logic  HaltedOut;
`ifdef PIPE_CTRL_PERF_EN
    logic [63:0] PerfStallCntOut;
    logic [63:0] PerfFlushCntOut;
    logic [63:0] PerfHaltCntOut;
`endif

    modport master (
        input  JumpFlagFromEx, JumpAddrFromEx, EbreakFromEx, HoldReqFromId, HoldReqFromMem,
        output JumpFlagToPc, JumpAddrToPc, StallPcOut, StallIfIdOut, StallIdExOut,
               FlushIfIdOut, FlushIdExOut, HaltedOut
`ifdef PIPE_CTRL_PERF_EN
        , output PerfStallCntOut, PerfFlushCntOut, PerfHaltCntOut
`endif
    );

    modport slave (
        output JumpFlagFromEx, JumpAddrFromEx, EbreakFromEx, HoldReqFromId, HoldReqFromMem,
        input  JumpFlagToPc, JumpAddrToPc, StallPcOut, StallIfIdOut, StallIdExOut,
               FlushIfIdOut, FlushIdExOut, HaltedOut
`ifdef PIPE_CTRL_PERF_EN
        , input PerfStallCntOut, PerfFlushCntOut, PerfHaltCntOut
`endif
    );

endinterface

// File: rtl/pipe_ctrl_perf.sv
// Free-running 64-bit event counters for pipe_ctrl; present only in builds
// with PIPE_CTRL_PERF_EN defined.
`ifdef PIPE_CTRL_PERF_EN
module pipe_ctrl_perf (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        stall_evt,
    input  logic        flush_evt,
    input  logic        halt_evt,
    output logic [63:0] stall_cnt,
    output logic [63:0] flush_cnt,
    output logic [63:0] halt_cnt
);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            halt_cnt  <= '0;
        end else begin
            stall_cnt <= stall_cnt + 64'(stall_evt);
            flush_cnt <= flush_cnt + 64'(flush_evt);
            halt_cnt  <= halt_cnt + 64'(halt_evt);
        end
    end

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: turns jump, load-use, memory-busy and EBREAK events into
// per-cycle stall/flush/redirect controls. PIPE_CTRL_PERF_EN adds event counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int    FLUSH_CYCLES = 2,
    parameter int    RESET_CYCLES = 2,
    parameter addr_t PC_RESET     = 64'h8000_0000
) (
    input logic         Clk,
    input logic         Rst,
    pipe_ctrl_if.master bus
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    ctrl_t            ctrl;

    always_comb begin
        // NOTE: defaults first so no branch can leave a signal unassigned and infer a latch.
        ctrl      = CTRL_IDLE;
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_RESET: begin
                ctrl = CTRL_HOLD_ALL;
                // Rst gating keeps the boot redirect quiet while reset is still held.
                if (cnt == '0 && Rst) begin
                    ctrl.jump = 1'b1;
                    state_nxt = ST_RUN;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.HoldReqFromMem) begin
                    ctrl = CTRL_HOLD_ALL;
                end else if (bus.EbreakFromEx) begin
                    ctrl             = CTRL_HOLD_ALL;
                    ctrl.flush_id_ex = 1'b1;
                    state_nxt        = ST_HALT;
                end else if (bus.JumpFlagFromEx) begin
                    ctrl.jump        = 1'b1;
                    ctrl.flush_if_id = 1'b1;
                    ctrl.flush_id_ex = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = ST_FLUSH;
                        cnt_nxt   = CNT_W'(FLUSH_CYCLES - 2);
                    end
                end else if (bus.HoldReqFromId) begin
                    ctrl.stall_pc    = 1'b1;
                    ctrl.stall_if_id = 1'b1;
                    ctrl.flush_id_ex = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Ex holds a bubble here, so only the memory hold is honoured.
                if (bus.HoldReqFromMem) begin
                    ctrl = CTRL_HOLD_ALL;
                end else if (cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
                ctrl.flush_id_ex = 1'b1;
            end
            ST_HALT: begin
                ctrl        = CTRL_HOLD_ALL;
                ctrl.halted = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (!Rst) begin
            state <= ST_RESET;
            cnt   <= CNT_W'(RESET_CYCLES - 1);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign bus.JumpFlagToPc = ctrl.jump;
    assign bus.JumpAddrToPc = !ctrl.jump          ? '0       :
                              (state == ST_RESET) ? PC_RESET : bus.JumpAddrFromEx;
    assign bus.StallPcOut   = ctrl.stall_pc;
    assign bus.StallIfIdOut = ctrl.stall_if_id;
    assign bus.StallIdExOut = ctrl.stall_id_ex;
    assign bus.FlushIfIdOut = ctrl.flush_if_id;
    assign bus.FlushIdExOut = ctrl.flush_id_ex;
    assign bus.HaltedOut    = ctrl.halted;

`ifdef PIPE_CTRL_PERF_EN
    logic stall_evt, flush_evt, halt_evt;

    assign stall_evt = (state == ST_RUN) && (ctrl.stall_pc || ctrl.stall_if_id || ctrl.stall_id_ex);
    assign flush_evt = (state == ST_RUN) && ctrl.jump;
    assign halt_evt  = (state == ST_HALT);

    pipe_ctrl_perf u_perf (
        .Clk       (Clk),
        .Rst       (Rst),
        .stall_evt (stall_evt),
        .flush_evt (flush_evt),
        .halt_evt  (halt_evt),
        .stall_cnt (bus.PerfStallCntOut),
        .flush_cnt (bus.PerfFlushCntOut),
        .halt_cnt  (bus.PerfHaltCntOut)
    );
`endif

`ifndef SYNTHESIS
    // Ex must not present a jump while the sequencer is still flushing.
    a_no_jump_in_flush: assert property (@(posedge Clk) disable iff (!Rst)
        !(state == ST_FLUSH && bus.JumpFlagFromEx))
        else $error("pipe_ctrl: JumpFlagFromEx asserted during flush");
`endif

endmodule
